// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus and FIFO write-port signals shared by the write arbiter.
// The master modport is the arbiter; the slave modport is the producers plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0]            req_drop;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic [IDX_W-1:0]              grant_id;
  logic                          drop_err;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output req_done, req_drop, fifo_data_in, fifo_wr_en, grant_id, drop_err
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  req_done, req_drop, fifo_data_in, fifo_wr_en, grant_id, drop_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; 3 cycles per word (IDLE->WRITE->CHECK).
// Holds off while fifo_full; overflowed writes are retried up to MAX_RETRY times, then dropped.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]            state;
  logic [IDX_W-1:0]      grant;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      pick;
  logic [IDX_W-1:0]      pick_hi;
  logic [IDX_W-1:0]      pick_lo;
  logic                  found_hi;
  logic [3:0]            retry;
  logic                  wr_en_q;
  logic [FIFO_WIDTH-1:0] data_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [NUM_REQ-1:0]    drop_q;
  logic                  drop_err_q;
  logic [NUM_REQ-1:0]    cand;
  logic [FIFO_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // A requester whose done is pulsing this cycle still shows its old word; skip it.
  assign cand = bus.req_valid & ~done_q;

  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_lo = IDX_W'(i);
        if (i > int'(last_grant)) begin
          found_hi = 1'b1;
          pick_hi  = IDX_W'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      retry      <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= '0;
      drop_q     <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= '0;
      drop_q  <= '0;
      case (state)
        IDLE: begin
          if (!bus.fifo_full) begin
            // A non-zero retry count means the grant is held for a re-issue.
            if (retry != 4'd0) begin
              state   <= WRITE;
              wr_en_q <= 1'b1;
              data_q  <= words[grant];
            end else if (|cand) begin
              state   <= WRITE;
              grant   <= pick;
              wr_en_q <= 1'b1;
              data_q  <= words[pick];
            end
          end
        end
        WRITE: state <= CHECK;
        CHECK: begin
          state <= IDLE;
          if (bus.fifo_wr_ack) begin
            done_q     <= NUM_REQ'(1) << grant;
            last_grant <= grant;
            retry      <= '0;
          end else if (retry < 4'(MAX_RETRY)) begin
            retry <= retry + 4'd1;
          end else begin
            done_q     <= NUM_REQ'(1) << grant;
            drop_q     <= NUM_REQ'(1) << grant;
            drop_err_q <= 1'b1;
            last_grant <= grant;
            retry      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so a word caught in WRITE is never written on the reset edge.
  assign bus.fifo_wr_en   = wr_en_q & rst_n;
  assign bus.fifo_data_in = data_q;
  assign bus.req_done     = done_q;
  assign bus.req_drop     = drop_q;
  assign bus.grant_id     = grant;
  assign bus.drop_err     = drop_err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO model that can be forced to overflow.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic f_rst_n;
  logic rd_en;
  logic force_ovf;
  logic [W-1:0] dat [NR];

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_RETRY(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.req_data = {dat[3], dat[2], dat[1], dat[0]};

  // FIFO model: registered wr_ack/overflow, combinational full
  logic [W-1:0] mem [8];
  logic [2:0]   wptr, rptr;
  int           f_count;
  logic         ack_q, ovf_q;
  logic [W-1:0] dout;
  logic         do_wr, do_rd;

  assign bus.fifo_full     = (f_count == 8);
  assign bus.fifo_wr_ack   = ack_q;
  assign bus.fifo_overflow = ovf_q;
  assign do_wr = bus.fifo_wr_en && (f_count != 8) && !force_ovf;
  assign do_rd = rd_en && (f_count != 0);

  always @(posedge clk) begin
    if (!f_rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      f_count <= 0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dout    <= '0;
    end else begin
      ack_q <= do_wr;
      ovf_q <= bus.fifo_wr_en && !do_wr;
      if (do_wr) begin
        mem[wptr] <= bus.fifo_data_in;
        wptr      <= wptr + 3'd1;
      end
      if (do_rd) begin
        dout <= mem[rptr];
        rptr <= rptr + 3'd1;
      end
      f_count <= f_count + int'(do_wr) - int'(do_rd);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; any write must belong to a valid requester.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.fifo_wr_en) chk("proto_valid_held", 32'(bus.req_valid[bus.grant_id]), 32'd1);
  endtask

  int n;
  int wr_cnt;
  int gen [NR];
  bit seen;

  initial begin
    rst_n = 1'b0;
    f_rst_n = 1'b0;
    rd_en = 1'b0;
    force_ovf = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) dat[i] = '0;
    tick();
    tick();
    rst_n = 1'b1;
    f_rst_n = 1'b1;
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
    chk("rst_done", 32'(bus.req_done), 32'd0);
    chk("rst_drop", 32'(bus.req_drop), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'd0);

    // 1: single write, exact latency
    bus.req_valid = 4'b0001;
    dat[0] = 16'hA5A5;
    tick();
    chk("t1_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    chk("t1_data", 32'(bus.fifo_data_in), 32'hA5A5);
    chk("t1_grant", 32'(bus.grant_id), 32'd0);
    tick();
    chk("t1_wr_en_one_cycle", 32'(bus.fifo_wr_en), 32'd0);
    chk("t1_done_early", 32'(bus.req_done), 32'd0);
    tick();
    chk("t1_done", 32'(bus.req_done), 32'b0001);
    chk("t1_drop", 32'(bus.req_drop), 32'd0);
    bus.req_valid = '0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1_fifo_out", 32'(dout), 32'hA5A5);
    chk("t1_done_pulse", 32'(bus.req_done), 32'd0);

    // 2: all requesters held, round-robin order from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      gen[i] = 0;
      dat[i] = 16'h1000 + 16'(i);
    end
    bus.req_valid = 4'b1111;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      tick();
      if (bus.req_done != '0) begin
        chk("t2_order", 32'(bus.req_done), 32'(1) << (n % 4));
        chk("t2_no_drop", 32'(bus.req_drop), 32'd0);
        for (int i = 0; i < NR; i++) begin
          if (bus.req_done[i]) begin
            gen[i]++;
            dat[i] = 16'h1000 + 16'(gen[i] * 4 + i);
          end
        end
        n++;
      end
    end
    bus.req_valid = '0;
    chk("t2_writes", 32'(n), 32'd8);
    chk("t2_full", 32'(bus.fifo_full), 32'd1);

    // 3: FIFO full blocks the write until one word is read
    bus.req_valid = 4'b0100;
    dat[2] = 16'hC3C3;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t3_no_wr_when_full", 32'(bus.fifo_wr_en), 32'd0);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t3_first_word", 32'(dout), 32'h1000);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.fifo_wr_en) begin
        chk("t3_data", 32'(bus.fifo_data_in), 32'hC3C3);
        chk("t3_grant", 32'(bus.grant_id), 32'd2);
      end
      if (bus.req_done != '0) begin
        chk("t3_done", 32'(bus.req_done), 32'b0100);
        seen = 1'b1;
        break;
      end
    end
    chk("t3_done_seen", 32'(seen), 32'd1);
    bus.req_valid = '0;

    // 4: forced overflow, three retries then drop
    f_rst_n = 1'b0;
    tick();
    f_rst_n = 1'b1;
    force_ovf = 1'b1;
    bus.req_valid = 4'b0010;
    dat[1] = 16'h7E7E;
    wr_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.fifo_wr_en) wr_cnt++;
      if (bus.req_done != '0) begin
        seen = 1'b1;
        chk("t4_done", 32'(bus.req_done), 32'b0010);
        chk("t4_drop", 32'(bus.req_drop), 32'b0010);
        chk("t4_drop_err", 32'(bus.drop_err), 32'd1);
        break;
      end
    end
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_wr_attempts", 32'(wr_cnt), 32'd4);
    bus.req_valid = '0;
    force_ovf = 1'b0;
    tick();
    tick();
    chk("t4_drop_pulse", 32'(bus.req_drop), 32'd0);
    chk("t4_drop_err_sticky", 32'(bus.drop_err), 32'd1);

    // 5: reset during WRITE abandons the word; arbitration restarts at requester 0
    dat[0] = 16'h0A0A;
    dat[3] = 16'h3B3B;
    bus.req_valid = 4'b1001;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.fifo_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_wr_seen", 32'(seen), 32'd1);
    chk("t5_grant_before", 32'(bus.grant_id), 32'd3);
    chk("t5_data_before", 32'(bus.fifo_data_in), 32'h3B3B);
    rst_n = 1'b0;
    #1;
    chk("t5_wr_en_in_rst", 32'(bus.fifo_wr_en), 32'd0);
    tick();
    chk("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("t5_rst_data", 32'(bus.fifo_data_in), 32'd0);
    chk("t5_rst_done", 32'(bus.req_done), 32'd0);
    chk("t5_rst_drop", 32'(bus.req_drop), 32'd0);
    chk("t5_rst_grant", 32'(bus.grant_id), 32'd0);
    chk("t5_rst_drop_err", 32'(bus.drop_err), 32'd0);
    chk("t5_fifo_count", 32'(f_count), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.fifo_wr_en) begin
        chk("t5_grant_after", 32'(bus.grant_id), 32'd0);
        chk("t5_data_after", 32'(bus.fifo_data_in), 32'h0A0A);
      end
      if (bus.req_done != '0) begin
        chk("t5_done", 32'(bus.req_done), 32'b0001);
        seen = 1'b1;
        break;
      end
    end
    chk("t5_done_seen", 32'(seen), 32'd1);
    bus.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
